// File: rtl/fnn_pkg.sv
// Shared definitions for the FNN weight path: loader FSM states and word width.
package fnn_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } loader_state_t;

endpackage : fnn_pkg

// File: rtl/w_mem_loader.sv
// Weight memory loader: turns a neuron-major valid/ready stream of weight words
// into one-cycle write strobes on the per-neuron weight memory write ports.
module w_mem_loader
    import fnn_pkg::*;
#(
    parameter int numNeurons   = 10,
    parameter int numWeight    = 30,
    parameter int addressWidth = $clog2(numWeight),
    parameter int neuronWidth  = $clog2(numNeurons),
    parameter int dataWidth    = DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [dataWidth-1:0]    s_data,
    input  logic                    s_last,
    output logic [numNeurons-1:0]   wen,
    output logic [addressWidth-1:0] wadd,
    output logic [dataWidth-1:0]    win,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [addressWidth-1:0] WCNT_MAX = addressWidth'(numWeight - 1);
    localparam logic [neuronWidth-1:0]  NCNT_MAX = neuronWidth'(numNeurons - 1);

    loader_state_t           state_reg;
    logic [addressWidth-1:0] wcnt_reg;
    logic [neuronWidth-1:0]  ncnt_reg;
    logic [numNeurons-1:0]   ncnt_onehot;
    logic                    handshake;
    logic                    wcnt_wrap;
    logic                    final_word;

    // One-hot decode of the neuron counter selecting which memory gets the word
    generate
        for (genvar gi = 0; gi < numNeurons; gi++) begin : g_onehot
            assign ncnt_onehot[gi] = (ncnt_reg == neuronWidth'(gi));
        end
    endgenerate

    // Status outputs are pure decodes of the state register, so nothing on the
    // stream inputs can reach s_ready combinationally.
    assign s_ready = (state_reg == LOAD);
    assign busy    = (state_reg == LOAD);
    assign done    = (state_reg == DONE);
    assign err     = (state_reg == ERR);

    assign handshake  = s_valid & s_ready;
    assign wcnt_wrap  = (wcnt_reg == WCNT_MAX);
    assign final_word = wcnt_wrap && (ncnt_reg == NCNT_MAX);

    // Loader FSM: counters, state and the registered memory write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            wcnt_reg  <= '0;
            ncnt_reg  <= '0;
            wen       <= '0;
            wadd      <= '0;
            win       <= '0;
        end else begin
            wen <= '0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= LOAD;
                        wcnt_reg  <= '0;
                        ncnt_reg  <= '0;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        // A premature s_last still gets its word written
                        wen  <= ncnt_onehot;
                        wadd <= wcnt_reg;
                        win  <= s_data;
                        if (wcnt_wrap) begin
                            wcnt_reg <= '0;
                            ncnt_reg <= ncnt_reg + 1'b1;
                        end else begin
                            wcnt_reg <= wcnt_reg + 1'b1;
                        end
                        if (final_word) begin
                            state_reg <= s_last ? DONE : ERR;
                        end else if (s_last) begin
                            state_reg <= ERR;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                ERR: begin
                    if (start) begin
                        state_reg <= LOAD;
                        wcnt_reg  <= '0;
                        ncnt_reg  <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule : w_mem_loader
